dbus_interconnect_n: RTL

- Parametrised N-slave data-bus interconnect; next generation of the fixed-map dbus decoder.
- Sits between the LSU data port and the peripheral/memory slaves.
- Decodes each request against a per-slave base/mask table and forwards it to exactly one slave, holding it until that slave acks or a timeout fires.
- Returns read data, or an error response for decode miss, misalignment or timeout; keeps error statistics.

---
 rtl/dbus_interconnect_n_if.sv | 36 +++
 rtl/dbus_interconnect_n.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dbus_interconnect_n_if.sv
// LSU-to-slaves data-bus bundle; master = LSU/slave-side environment, slave = interconnect.
// Signals are level/strobe based; no queueing lives on this boundary.
interface dbus_interconnect_n_if #(
  parameter int NUM_SLAVES = 8,
  parameter int ADDR_W     = 32
) ();
  logic                     m_req_i;
  logic                     m_wen_i;
  logic [ADDR_W-1:0]        m_addr_i;
  logic [1:0]               m_size_i;
  logic [31:0]              m_wdata_i;
  logic                     m_ack_o;
  logic                     m_err_o;
  logic [31:0]              m_rdata_o;
  logic [NUM_SLAVES-1:0]    s_req_o;
  logic                     s_wen_o;
  logic [ADDR_W-1:0]        s_addr_o;
  logic [31:0]              s_wdata_o;
  logic [3:0]               s_sel_byte_o;
  logic [NUM_SLAVES-1:0]    s_ack_i;
  logic [NUM_SLAVES*32-1:0] s_rdata_i;
  logic [7:0]               err_cnt_o;
  logic [ADDR_W-1:0]        err_addr_o;

  modport master (
    output m_req_i, m_wen_i, m_addr_i, m_size_i, m_wdata_i, s_ack_i, s_rdata_i,
    input  m_ack_o, m_err_o, m_rdata_o, s_req_o, s_wen_o, s_addr_o, s_wdata_o,
           s_sel_byte_o, err_cnt_o, err_addr_o
  );

  modport slave (
    input  m_req_i, m_wen_i, m_addr_i, m_size_i, m_wdata_i, s_ack_i, s_rdata_i,
    output m_ack_o, m_err_o, m_rdata_o, s_req_o, s_wen_o, s_addr_o, s_wdata_o,
           s_sel_byte_o, err_cnt_o, err_addr_o
  );
endinterface

// File: rtl/dbus_interconnect_n.sv
// N-slave data-bus decoder: base/mask decode, lane placement, timeout and error statistics.
// Latency req->ack 2 cycles on a zero-wait slave, 1 on decode/alignment error; master held by req until ack.
module dbus_interconnect_n #(
  parameter int                           NUM_SLAVES  = 8,
  parameter int                           ADDR_W      = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE    = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK    = '0,
  parameter int                           TIMEOUT_CYC = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  dbus_interconnect_n_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]            state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [CNT_W-1:0]      tmo_cnt_q;
  logic [ADDR_W-1:0]     s_addr_q;
  logic [31:0]           s_wdata_q;
  logic [3:0]            s_sel_q;
  logic                  s_wen_q;
  logic                  m_err_q;
  logic [31:0]           m_rdata_q;
  logic [7:0]            err_cnt_q;
  logic [ADDR_W-1:0]     err_addr_q;

  logic                  hit_any;
  logic [IDX_W-1:0]      hit_idx;
  logic                  align_ok;
  logic [31:0]           lane_dat;
  logic [3:0]            lane_sel;
  logic [NUM_SLAVES-1:0] s_req;
  logic                  sel_ack;
  logic [31:0]           sel_rdata;
  logic                  tmo_hit;
  logic                  req_ok;
  logic                  req_bad;
  logic                  enter_err;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((bus.m_addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    align_ok = 1'b0;
    lane_dat = '0;
    lane_sel = '0;
    case (bus.m_size_i)
      2'b00: begin
        align_ok = 1'b1;
        lane_dat = {24'd0, bus.m_wdata_i[7:0]} << {bus.m_addr_i[1:0], 3'b000};
        lane_sel = 4'b0001 << bus.m_addr_i[1:0];
      end
      2'b01: begin
        align_ok = ~bus.m_addr_i[0];
        lane_dat = {16'd0, bus.m_wdata_i[15:0]} << {bus.m_addr_i[1], 4'b0000};
        lane_sel = bus.m_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        align_ok = (bus.m_addr_i[1:0] == 2'b00);
        lane_dat = bus.m_wdata_i;
        lane_sel = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_req = '0;
    if (state_q == ST_ACTIVE) s_req[idx_q] = 1'b1;
  end

  assign sel_ack   = bus.s_ack_i[idx_q];
  assign sel_rdata = bus.s_rdata_i[{idx_q, 5'd0} +: 32];
  assign tmo_hit   = (TIMEOUT_CYC != 0) && (tmo_cnt_q == TMO_LAST);
  assign req_ok    = bus.m_req_i && hit_any && align_ok;
  assign req_bad   = bus.m_req_i && !(hit_any && align_ok);
  assign enter_err = ((state_q == ST_IDLE) && req_bad) ||
                     ((state_q == ST_ACTIVE) && !sel_ack && tmo_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      tmo_cnt_q <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_sel_q   <= '0;
      s_wen_q   <= 1'b0;
      m_err_q   <= 1'b0;
      m_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_ok) begin
            state_q   <= ST_ACTIVE;
            idx_q     <= hit_idx;
            tmo_cnt_q <= '0;
            s_addr_q  <= bus.m_addr_i;
            s_wdata_q <= lane_dat;
            s_sel_q   <= lane_sel;
            s_wen_q   <= bus.m_wen_i;
          end else if (req_bad) begin
            state_q   <= ST_RESP;
            m_err_q   <= 1'b1;
            m_rdata_q <= '0;
          end
        end
        ST_ACTIVE: begin
          if (sel_ack) begin
            state_q   <= ST_RESP;
            m_err_q   <= 1'b0;
            m_rdata_q <= s_wen_q ? 32'd0 : sel_rdata;
          end else if (tmo_hit) begin
            state_q   <= ST_RESP;
            m_err_q   <= 1'b1;
            m_rdata_q <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The faulting address comes from the live request on a decode miss, from the held one on timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else if (enter_err) begin
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      err_addr_q <= (state_q == ST_IDLE) ? bus.m_addr_i : s_addr_q;
    end
  end

  assign bus.m_ack_o      = (state_q == ST_RESP);
  assign bus.m_err_o      = m_err_q;
  assign bus.m_rdata_o    = m_rdata_q;
  assign bus.s_req_o      = s_req;
  assign bus.s_wen_o      = s_wen_q;
  assign bus.s_addr_o     = s_addr_q;
  assign bus.s_wdata_o    = s_wdata_q;
  assign bus.s_sel_byte_o = s_sel_q;
  assign bus.err_cnt_o    = err_cnt_q;
  assign bus.err_addr_o   = err_addr_q;

endmodule
